// File: rtl/spike_dec_pkg.sv
// Shared constants and helpers for the spike rate decoder slice.
package spike_dec_pkg;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_COUNT_W     = 4;
    localparam int unsigned DEF_WINDOW_LOG2 = 6;
    localparam int unsigned CNT_MAX         = (1 << DEF_COUNT_W) - 1;

    // Width of a channel index; never zero even for a single channel.
    function automatic int unsigned win_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Snapshot output port of the spike rate decoder: rate vector, winner, valid/ready.
interface spike_rate_decoder_if
    import spike_dec_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned COUNT_W = DEF_COUNT_W
);
    localparam int unsigned WIN_W  = win_w(N_CH);
    localparam int unsigned RATE_W = N_CH * COUNT_W;

    logic [RATE_W-1:0] rate_out;
    logic [WIN_W-1:0]  winner;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output rate_out,
        output winner,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rate_out,
        input  winner,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/spike_edge_counter.sv
// One channel: rising-edge detect plus saturating per-window spike accumulator.
module spike_edge_counter
    import spike_dec_pkg::*;
#(
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spike,
    input  logic               clr,
    input  logic               close,
    output logic [COUNT_W-1:0] snap_c
);
    localparam logic [COUNT_W-1:0] SAT = '1;

    logic               prev_q, prev_d;
    logic [COUNT_W-1:0] acc_q, acc_d;
    logic               edge_c;

    // snap_c includes an edge landing on the close cycle itself.
    always_comb begin
        prev_d = spike;
        edge_c = spike & ~prev_q;
        snap_c = acc_q;
        if (edge_c && (acc_q != SAT)) begin
            snap_c = acc_q + COUNT_W'(1);
        end
        acc_d = snap_c;
        if (clr || close) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            prev_q <= prev_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike counting per channel, argmax winner, and a one-deep valid/ready snapshot.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter int unsigned WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_CH-1:0]      spike_in,
    input  logic                 clr_overrun,
    output logic                 overrun,
    spike_rate_decoder_if.master out_if
);
    localparam int unsigned WIN_W  = win_w(N_CH);
    localparam int unsigned RATE_W = N_CH * COUNT_W;

    logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
    logic                   close_c;
    logic                   clr_c;
    logic [COUNT_W-1:0]     snap_c [N_CH];
    logic [RATE_W-1:0]      rate_c;
    logic [WIN_W-1:0]       win_c;
    logic [COUNT_W-1:0]     best_c;
    logic                   xfer_c;

    logic [RATE_W-1:0]      rate_q, rate_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    // Window counter wraps naturally after its all-ones close cycle.
    always_comb begin
        clr_c   = ~en;
        close_c = en && (wcnt_q == '1);
        wcnt_d  = en ? (wcnt_q + WINDOW_LOG2'(1)) : '0;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_edge_counter #(
            .COUNT_W (COUNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .spike  (spike_in[g]),
            .clr    (clr_c),
            .close  (close_c),
            .snap_c (snap_c[g])
        );
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        rate_c = '0;
        win_c  = '0;
        best_c = snap_c[0];
        for (int unsigned i = 0; i < N_CH; i++) begin
            rate_c[i*COUNT_W +: COUNT_W] = snap_c[i];
            if (snap_c[i] > best_c) begin
                best_c = snap_c[i];
                win_c  = WIN_W'(i);
            end
        end
    end

    // A close with a full, stalled output drops the snapshot; set beats clear.
    always_comb begin
        xfer_c    = valid_q & out_if.out_ready;
        valid_d   = valid_q & ~xfer_c;
        rate_d    = rate_q;
        win_d     = win_q;
        overrun_d = overrun_q & ~clr_overrun;
        if (close_c) begin
            if (!valid_q || out_if.out_ready) begin
                rate_d  = rate_c;
                win_d   = win_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            rate_q    <= '0;
            win_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            rate_q    <= rate_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.rate_out  = rate_q;
    assign out_if.winner    = win_q;
    assign out_if.out_valid = valid_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: cycle model pushes snapshots, transfers pop and compare.
module tb_spike_rate_decoder;
    import spike_dec_pkg::*;

    typedef struct packed {
        logic [15:0] rate;
        logic [1:0]  win;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] spike_in;
    logic       clr_overrun;
    logic       overrun;

    spike_rate_decoder_if #(.N_CH(4), .COUNT_W(4)) bus ();

    spike_rate_decoder #(
        .N_CH        (4),
        .COUNT_W     (4),
        .WINDOW_LOG2 (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .spike_in    (spike_in),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .out_if      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model state
    bit         m_valid;
    bit         m_overrun;
    int         m_w;
    int         m_acc [4];
    logic [3:0] m_prev;

    logic [3:0] pat [64];

    task automatic model_reset();
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_w       = 0;
        m_prev    = 4'b0;
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        sb.delete();
    endtask

    // Compare outputs against the model, advance the model, then clock once.
    task automatic step();
        logic [3:0] e;
        int         s;
        int         best;
        exp_t       x;
        bit         close;
        checks++;
        if (bus.out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid got %b exp %b t=%0t", bus.out_valid, m_valid, $time);
        end
        checks++;
        if (overrun !== m_overrun) begin
            errors++;
            $display("FAIL overrun got %b exp %b t=%0t", overrun, m_overrun, $time);
        end
        if (m_valid && sb.size() > 0) begin
            checks++;
            if (bus.rate_out !== sb[0].rate || bus.winner !== sb[0].win) begin
                errors++;
                $display("FAIL snapshot got %h/%0d exp %h/%0d t=%0t",
                         bus.rate_out, bus.winner, sb[0].rate, sb[0].win, $time);
            end
        end
        if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
            void'(sb.pop_front());
        end
        if (clr_overrun) m_overrun = 1'b0;
        e      = spike_in & ~m_prev;
        m_prev = spike_in;
        if (!en) begin
            m_w = 0;
            for (int i = 0; i < 4; i++) m_acc[i] = 0;
        end else begin
            close = (m_w == 63);
            x     = '0;
            best  = -1;
            for (int i = 0; i < 4; i++) begin
                s = m_acc[i] + int'(e[i]);
                if (s > int'(CNT_MAX)) s = int'(CNT_MAX);
                x.rate[i*4 +: 4] = 4'(s);
                if (s > best) begin
                    best  = s;
                    x.win = 2'(i);
                end
                m_acc[i] = close ? 0 : s;
            end
            if (close) begin
                if (!m_valid || bus.out_ready) begin
                    sb.push_back(x);
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
                m_w = 0;
            end else begin
                m_w++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat();
        for (int c = 0; c < 64; c++) pat[c] = 4'b0;
    endtask

    task automatic run_pattern();
        en = 1'b1;
        for (int c = 0; c < 64; c++) begin
            spike_in = pat[c];
            step();
        end
        spike_in = 4'b0;
    endtask

    task automatic realign();
        en       = 1'b0;
        spike_in = 4'b0;
        bus.out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        bit found = 1'b0;
        while (!found && k < 100) begin
            step();
            k++;
            if (bus.out_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || k != 64) begin
            errors++;
            $display("FAIL %s latency got %0d exp 64 (found=%0b)", name, k, found);
        end
        checks++;
        if (bus.rate_out !== 16'h0000 || bus.winner !== 2'd0) begin
            errors++;
            $display("FAIL %s zero snapshot got %h/%0d exp 0000/0", name, bus.rate_out, bus.winner);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; spike_in = 4'b0; clr_overrun = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rate_out !== 16'h0 || bus.winner !== 2'd0 || bus.out_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got %h/%0d/%b/%b exp 0/0/0/0",
                     bus.rate_out, bus.winner, bus.out_valid, overrun);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        en = 1'b1; bus.out_ready = 1'b0; spike_in = 4'b0;
        wait_valid("idle");
        repeat (6) step();
        realign();
    endtask

    task automatic test_mixed();
        clear_pat();
        foreach (pat[c]) pat[c][2] = 1'b1;
        pat[2][0] = 1'b1; pat[10][0] = 1'b1; pat[20][0] = 1'b1;
        pat[5][1] = 1'b1; pat[15][1] = 1'b1; pat[25][1] = 1'b1; pat[35][1] = 1'b1; pat[45][1] = 1'b1;
        bus.out_ready = 1'b1;
        run_pattern();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rate_out !== 16'h0153 || bus.winner !== 2'd1) begin
            errors++;
            $display("FAIL mixed got %b/%h/%0d exp 1/0153/1", bus.out_valid, bus.rate_out, bus.winner);
        end
        realign();
    endtask

    task automatic test_sat_boundary();
        clear_pat();
        for (int c = 0; c < 64; c += 2) pat[c][3] = 1'b1;
        pat[63][0] = 1'b1;
        bus.out_ready = 1'b1;
        run_pattern();
        checks++;
        if (bus.rate_out !== 16'hF001 || bus.winner !== 2'd3) begin
            errors++;
            $display("FAIL saturate got %h/%0d exp F001/3", bus.rate_out, bus.winner);
        end
        clear_pat();
        pat[0][1] = 1'b1;
        run_pattern();
        checks++;
        if (bus.rate_out !== 16'h0010 || bus.winner !== 2'd1) begin
            errors++;
            $display("FAIL after_close got %h/%0d exp 0010/1", bus.rate_out, bus.winner);
        end
        realign();
    endtask

    task automatic test_tie();
        clear_pat();
        pat[1][1] = 1'b1; pat[3][1] = 1'b1; pat[5][1] = 1'b1; pat[7][1] = 1'b1;
        pat[10][2] = 1'b1; pat[20][2] = 1'b1; pat[30][2] = 1'b1; pat[40][2] = 1'b1;
        bus.out_ready = 1'b1;
        run_pattern();
        checks++;
        if (bus.rate_out !== 16'h0440 || bus.winner !== 2'd1) begin
            errors++;
            $display("FAIL tie got %h/%0d exp 0440/1", bus.rate_out, bus.winner);
        end
        realign();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        clear_pat();
        pat[4][0] = 1'b1; pat[8][0] = 1'b1;
        run_pattern();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rate_out !== 16'h0002 || bus.winner !== 2'd0) begin
            errors++;
            $display("FAIL bp_first got %b/%h/%0d exp 1/0002/0", bus.out_valid, bus.rate_out, bus.winner);
        end
        clear_pat();
        pat[3][2] = 1'b1; pat[6][2] = 1'b1; pat[9][2] = 1'b1;
        run_pattern();
        checks++;
        if (bus.rate_out !== 16'h0002 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_drop got %h/ovr=%b exp 0002/ovr=1", bus.rate_out, overrun);
        end
        clear_pat();
        pat[30][3] = 1'b1;
        for (int c = 0; c < 64; c++) begin
            spike_in      = pat[c];
            clr_overrun   = (c == 0);
            bus.out_ready = (c == 63);
            step();
            if (c == 0) begin
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_overrun got %b exp 0", overrun);
                end
            end
        end
        clr_overrun = 1'b0;
        bus.out_ready = 1'b0;
        spike_in = 4'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rate_out !== 16'h1000 || bus.winner !== 2'd3) begin
            errors++;
            $display("FAIL bp_reload got %b/%h/%0d exp 1/1000/3", bus.out_valid, bus.rate_out, bus.winner);
        end
        realign();
    endtask

    task automatic test_en_drop();
        en = 1'b1; bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            spike_in = {3'b000, ~c[0]};
            step();
        end
        spike_in = 4'b0;
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        wait_valid("en_drop");
        realign();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        clear_pat();
        pat[5][2] = 1'b1; pat[9][2] = 1'b1;
        run_pattern();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.rate_out !== 16'h0200 || bus.winner !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset got %b/%h/%0d exp 1/0200/2", bus.out_valid, bus.rate_out, bus.winner);
        end
        for (int c = 0; c < 20; c++) begin
            spike_in = {2'b00, c[1], 1'b0};
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rate_out !== 16'h0 || bus.winner !== 2'd0 || bus.out_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h/%0d/%b/%b exp 0/0/0/0",
                     bus.rate_out, bus.winner, bus.out_valid, overrun);
        end
        model_reset();
        spike_in = 4'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        wait_valid("post_reset");
        realign();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_mixed();
        test_sat_boundary();
        test_tie();
        test_backpressure();
        test_en_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
